// File: rtl/matrix_rom_seq.sv
// Streams packed matrix words from a small register-file ROM, either the whole matrix or one column.
// Optional write port enabled by defining MATRIX_ROM_SEQ_WR_EN; otherwise contents stay at reset values.
module matrix_rom_seq #(
   parameter int DATA_W = 7,
   parameter int ROWS   = 8,
   parameter int COLS   = 4,
   parameter int PACK   = 2,
   localparam int WPC   = ROWS / PACK,
   localparam int DEPTH = COLS * WPC,
   localparam int W     = PACK * DATA_W,
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [CW-1:0] col_sel,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data
);

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   state_e        state_q, state_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  data_q, data_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] end_q, end_d;
   logic          last_q, last_d;
   logic          done_q, done_d;

   logic [CW-1:0] col_eff;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] next_addr;

   // Lowest row of each word sits in the most significant element slot.
   function automatic logic [W-1:0] init_word(input int a);
      logic [W-1:0] word;
      int c;
      int r;
      word = '0;
      c = a / WPC;
      for (int p = 0; p < PACK; p++) begin
         r = (a % WPC) * PACK + p;
         word[(PACK-1-p)*DATA_W +: DATA_W] = (c == 0) ? DATA_W'(r + 1) : DATA_W'(1);
      end
      return word;
   endfunction

   always_comb begin
      col_eff   = (col_sel > COL_MAX) ? COL_MAX : col_sel;
      base_addr = '0;
      end_addr  = AW'(DEPTH - 1);
      if (mode) begin
         base_addr = AW'(col_eff) * AW'(WPC);
         end_addr  = base_addr + AW'(WPC - 1);
      end
      next_addr = addr_q + AW'(1);
   end

   // Fetches read mem_q before the same-edge write lands, giving read-first behaviour.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      end_d   = end_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               state_d = RUN;
               addr_d  = base_addr;
               end_d   = end_addr;
               data_d  = mem_q[base_addr];
               last_d  = (base_addr == end_addr);
            end
         end
         RUN: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  addr_d = next_addr;
                  data_d = mem_q[next_addr];
                  last_d = (next_addr == end_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         addr_q  <= '0;
         end_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            mem_q[a] <= init_word(a);
         end
`ifdef MATRIX_ROM_SEQ_WR_EN
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
`endif
      end
   end

`ifndef MATRIX_ROM_SEQ_WR_EN
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

   assign out_data  = data_q;
   assign out_valid = (state_q == RUN);
   assign out_last  = last_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

endmodule

// File: tb/tb_matrix_rom_seq.sv
// Directed bench for matrix_rom_seq at default parameters; expectations follow MATRIX_ROM_SEQ_WR_EN.
module tb_matrix_rom_seq;

   localparam int W = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [1:0]    col_sel = '0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          wr_en = 1'b0;
   logic [3:0]    wr_addr = '0;
   logic [W-1:0]  wr_data = '0;

   int tests_run = 0;
   int tests_failed = 0;
   logic [W-1:0] exp_q[$];

   matrix_rom_seq dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .col_sel(col_sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic push_col0();
      exp_q.push_back(14'h082);
      exp_q.push_back(14'h184);
      exp_q.push_back(14'h286);
      exp_q.push_back(14'h388);
   endtask

   task automatic begin_stream(input logic m, input logic [1:0] c);
      @(negedge clk);
      start = 1'b1;
      mode = m;
      col_sel = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consume exp_q; optional stall on one word, start pokes, and writes around the stalled word.
   task automatic drain(input string tag, input int stall_at, input int stall_n,
                        input bit poke, input bit do_wr);
      int idx = 0;
      int stall_left = stall_n;
      int cyc = 0;
      int n_words = exp_q.size();
      bit fin = 1'b0;
      while (!fin && cyc < 200) begin
         out_ready = !(idx == stall_at && stall_left > 0);
         start = poke && (cyc == 2 || cyc == 5);
         wr_en = 1'b0;
         if (do_wr && idx == stall_at) begin
            wr_en = 1'b1;
            wr_addr = out_ready ? 4'(idx + 1) : 4'(idx);
            wr_data = out_ready ? 14'h2AAA : 14'h1555;
         end
         chk({tag, " valid"}, out_valid, 1);
         chk({tag, " busy"}, busy, 1);
         chk({tag, " data"}, out_data, exp_q[0]);
         chk({tag, " last"}, out_last, (exp_q.size() == 1));
         if (out_ready) begin
            void'(exp_q.pop_front());
            idx++;
            if (exp_q.size() == 0) fin = 1'b1;
         end else begin
            stall_left--;
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 1'b0;
      out_ready = 1'b1;
      chk({tag, " finished"}, fin, 1);
      chk({tag, " cycles"}, cyc, n_words + stall_n);
      start = poke;
      chk({tag, " done pulse"}, done, 1);
      chk({tag, " done valid"}, out_valid, 0);
      chk({tag, " done busy"}, busy, 0);
      @(negedge clk);
      start = 1'b0;
      chk({tag, " done low"}, done, 0);
      chk({tag, " idle valid"}, out_valid, 0);
      chk({tag, " idle busy"}, busy, 0);
      exp_q.delete();
   endtask

   initial begin
      // Reset with start and a write asserted: both must be overridden.
      rst = 1'b1;
      start = 1'b1;
      wr_en = 1'b1;
      wr_addr = 4'd0;
      wr_data = 14'h3FFF;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      chk("rst valid", out_valid, 0);
      chk("rst last", out_last, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst data", out_data, 0);

      // Full matrix, with start poked during RUN and in the done cycle.
      push_col0();
      for (int i = 0; i < 12; i++) exp_q.push_back(14'h081);
      begin_stream(1'b0, 2'd0);
      drain("mode0", -1, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("poke ignored valid", out_valid, 0);

      // Single column 2: addresses 8..11.
      for (int i = 0; i < 4; i++) exp_q.push_back(14'h081);
      begin_stream(1'b1, 2'd2);
      drain("col2", -1, 0, 1'b0, 1'b0);

      // Column 0 with 3-cycle stall on word 2; writes during the stall and at its handshake.
      push_col0();
      begin_stream(1'b1, 2'd0);
      drain("stall", 1, 3, 1'b0, 1'b1);

      // Fresh contents, then a single write to address 1.
      do_reset();
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = 4'd1;
      wr_data = 14'h3FFF;
      @(negedge clk);
      wr_en = 1'b0;
      exp_q.push_back(14'h082);
`ifdef MATRIX_ROM_SEQ_WR_EN
      exp_q.push_back(14'h3FFF);
`else
      exp_q.push_back(14'h184);
`endif
      exp_q.push_back(14'h286);
      exp_q.push_back(14'h388);
      begin_stream(1'b1, 2'd0);
      drain("write", -1, 0, 1'b0, 1'b0);

      // Abort with reset while word 5 is presented.
      begin_stream(1'b0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         chk("abort pre valid", out_valid, 1);
         @(negedge clk);
      end
      chk("abort word5", out_data, 14'h081);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort valid", out_valid, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort data", out_data, 0);
      @(negedge clk);
      chk("abort no done", done, 0);
      push_col0();
      for (int i = 0; i < 12; i++) exp_q.push_back(14'h081);
      begin_stream(1'b0, 2'd0);
      drain("restart", -1, 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
